// File: rtl/logic_gates_tester.sv
`default_nettype none
// =============================================================================
// Module   : logic_gates_tester
// Brief    : Walks {A,B} through 00..11, checks the 7-output gate bank and
//            reports a saturating mismatch count, a pass flag and a done pulse.
//            Define LOGIC_GATES_TESTER_DIAG_EN to add first-failure capture.
// Revision : 1.0
// =============================================================================
module logic_gates_tester #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [6:0]       gates_i,
  output logic             a_o,
  output logic             b_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
`ifdef LOGIC_GATES_TESTER_DIAG_EN
  output logic [1:0]       fail_vec_o,
  output logic [6:0]       fail_mask_o,
`endif
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam int               CNT_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef LOGIC_GATES_TESTER_DIAG_EN
  logic [1:0]       fail_vec_q, fail_vec_d;
  logic [6:0]       fail_mask_q, fail_mask_d;
`endif

  logic [6:0] w_expected;
  logic [6:0] w_diff;
  logic       w_mismatch;

  // Bit order {XNOR,XOR,NOT,NOR,OR,NAND,AND}, derived from the registered stimulus.
  assign w_expected = {~(a_q ^ b_q), a_q ^ b_q, ~a_q, ~(a_q | b_q),
                       a_q | b_q, ~(a_q & b_q), a_q & b_q};
  assign w_diff     = gates_i ^ w_expected;
  assign w_mismatch = |w_diff;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_cnt_d = err_cnt_q;
    cnt_d     = cnt_q;
`ifdef LOGIC_GATES_TESTER_DIAG_EN
    fail_vec_d  = fail_vec_q;
    fail_mask_d = fail_mask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          a_d       = 1'b0;
          b_d       = 1'b0;
          cnt_d     = SETTLE_LD;
          err_cnt_d = '0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
`ifdef LOGIC_GATES_TESTER_DIAG_EN
          fail_vec_d  = 2'b00;
          fail_mask_d = 7'b0;
`endif
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (w_mismatch) begin
            if (err_cnt_q != ERR_MAX) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
`ifdef LOGIC_GATES_TESTER_DIAG_EN
            // A zero count means no earlier vector of this run has failed.
            if (err_cnt_q == '0) begin
              fail_vec_d  = {a_q, b_q};
              fail_mask_d = w_diff;
            end
`endif
          end
          if ({a_q, b_q} == 2'b11) begin
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_q == '0) && !w_mismatch;
            state_d = ST_FIN;
          end else begin
            {a_d, b_d} = {a_q, b_q} + 2'd1;
            cnt_d      = SETTLE_LD;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
      cnt_q     <= '0;
`ifdef LOGIC_GATES_TESTER_DIAG_EN
      fail_vec_q  <= 2'b00;
      fail_mask_q <= 7'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_cnt_q <= err_cnt_d;
      cnt_q     <= cnt_d;
`ifdef LOGIC_GATES_TESTER_DIAG_EN
      fail_vec_q  <= fail_vec_d;
      fail_mask_q <= fail_mask_d;
`endif
    end
  end

  assign a_o       = a_q;
  assign b_o       = b_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign err_cnt_o = err_cnt_q;
`ifdef LOGIC_GATES_TESTER_DIAG_EN
  assign fail_vec_o  = fail_vec_q;
  assign fail_mask_o = fail_mask_q;
`endif

endmodule
`default_nettype wire
